afifo_wr_ctrl: RTL and testbench
================================

Name: afifo_wr_ctrl

Overview:
- Write-side controller for the async FIFO, running in the write clock domain (clka).
- Accepts push requests and drives the register file write port (ena/wra/addra/dina).
- Keeps the binary and Gray write pointers and synchronises the read-domain Gray pointer.
- Generates full, almost-full, fill level and a sticky overflow flag. It is the writer counterpart of the read port on clkb.

Parameters:
- WIDTH, 8, data word width.
- ADDR, 6, RF address width; DEPTH = 2^ADDR; legal ADDR >= 2.
- AFULL_TH, 4, afull asserts when free slots <= AFULL_TH; legal 1..DEPTH-1.

Ports:
- clka, input, 1, write-domain clock.
- rsta, input, 1, reset; asynchronous, active-high; clock clka.
- wr_req, input, 1, push request, sampled at posedge clka.
- wr_data, input, WIDTH, push data.
- ovf_clr, input, 1, clears the overflow flag.
- rptr_gray_b, input, ADDR+1, read pointer in Gray code from the clkb domain; asynchronous to clka.
- ram_en, output, 1, RF write-port enable (ena).
- ram_wr, output, 1, RF write strobe (wra).
- ram_addr, output, ADDR, RF write address (addra).
- ram_din, output, WIDTH, RF write data (dina).
- wptr_gray, output, ADDR+1, registered Gray write pointer, sent to the read domain.
- full, output, 1, FIFO full (registered).
- afull, output, 1, almost full (registered).
- wr_count, output, ADDR+1, fill level as seen from the write side (registered), range 0..DEPTH.
- ovf, output, 1, sticky overflow flag.

Behaviour:
- Reset (async on rsta): wbin = 0, wptr_gray = 0, both sync flops = 0, full = 0, afull = 0, wr_count = 0, ovf = 0. Outputs take these values immediately on assertion, mid-transfer included; any in-flight push is dropped. Drive the RF with the same rsta.
- Accept: accept = wr_req & ~full.
- RF drive, combinational:
  - ram_en = ram_wr = accept.
  - ram_addr = wbin[ADDR-1:0].
  - ram_din = wr_data.
  - The RF captures the word on the same clka edge that advances the pointer.
- Pointer update: on accept, wbin <= wbin+1, modulo 2^(ADDR+1). wptr_gray <= wbin_next ^ (wbin_next >> 1). wptr_gray changes by exactly one bit per accept and is glitch-free (flop output only).
- Synchroniser:
  - rq1 <= rptr_gray_b; rq2 <= rq1.
  - rbin_s = Gray-to-binary(rq2).
  - No other logic may sample rptr_gray_b directly.
- Full:
  - full <= (gray_next == {~rq2[ADDR:ADDR-1], rq2[ADDR-2:0]}), where gray_next is the Gray value of wbin_next.
  - full rises in the cycle right after the accept that fills entry DEPTH, so a registered-full writer can never overwrite.
  - full falls no earlier than the 3rd clka edge after rptr_gray_b changes (2 sync + 1 register). This is pessimistic and safe.
- Fill level and almost full:
  - wr_count <= wbin_next - rbin_s, modulo 2^(ADDR+1).
  - afull <= (wbin_next - rbin_s) >= DEPTH - AFULL_TH.
  - full implies afull.
- Overflow:
  - Set on wr_req & full; no RF write and no pointer change occur.
  - Cleared on ovf_clr.
  - If set and clear happen in the same cycle, set wins.
- Wrap-around: ram_addr wraps DEPTH-1 -> 0. The extra MSB of wbin distinguishes full from empty. Gray wraps gray(2^(ADDR+1)-1) -> 0 with one bit change.
- Simultaneous push and read-pointer advance: the flags use the synchronised read value only. They are allowed to be stale and conservative; they must never be optimistic.
- No combinational path from rptr_gray_b to any output.

Test Plan:
- Reset: assert rsta mid-cycle with wr_req=1 -> all outputs 0 immediately; ram_en=0 while rsta is high; the first push after release writes ram_addr=0.
- Fill (ADDR=6, rptr_gray_b=0):
  - Push 64 words 0x00..0x3F on consecutive cycles -> ram_addr 0..63 with ram_din equal to the index.
  - full=1 in the cycle after the 64th accept.
  - wptr_gray=7'b1100000, wr_count=64.
  - afull=1 from the cycle after accept #60.
- Overflow: with full=1, wr_req=1 for 2 cycles -> ram_en=0, wptr_gray unchanged, ovf=1; ovf_clr=1 with wr_req=1 in the same cycle -> ovf stays 1; ovf_clr alone -> ovf=0.
- Release: from full, set rptr_gray_b=7'b0000001 (one word read) -> full=0 exactly on the 3rd clka edge, wr_count=63; the next push writes ram_addr=0 (wrapped), then full=1 again.
- Long wrap: 300 pushes with rptr_gray_b tracking wptr_gray two cycles late -> full never asserts; every wptr_gray step differs by one bit, including the 127->0 pointer wrap; no ram_addr is written while its slot is unread.
- Random: random wr_req and random read-pointer advance (Gray-coded, clkb ratio 1.7) against a scoreboard -> no overwrite, no lost word; wr_count is never below the true occupancy.

Source files
------------

// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO (clka domain).
// Accepts pushes, drives the register-file write port, and keeps the binary and
// Gray write pointers. It brings the read-side Gray pointer across through a
// two-flop synchroniser and derives the full, almost-full, fill-level and sticky
// overflow flags from it. The flags only ever see the synchronised, and therefore
// older, read pointer. They can be pessimistic but never optimistic.
`timescale 1ns/1ps
module afifo_wr_ctrl #(
    parameter int WIDTH    = 8,
    parameter int ADDR     = 6,
    parameter int AFULL_TH = 4
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              wr_req,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              ovf_clr,
    input  logic [ADDR:0]     rptr_gray_b,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR-1:0]   ram_addr,
    output logic [WIDTH-1:0]  ram_din,
    output logic [ADDR:0]     wptr_gray,
    output logic              full,
    output logic              afull,
    output logic [ADDR:0]     wr_count,
    output logic              ovf
);

    localparam int            DEPTH     = 1 << ADDR;
    // Fill level at which free slots drop to AFULL_TH or fewer.
    localparam logic [ADDR:0] AFULL_LVL = (ADDR+1)'(DEPTH - AFULL_TH);

    logic [ADDR:0] wbin_q, wbin_d;
    logic [ADDR:0] wgray_q, wgray_d;
    logic [ADDR:0] rq1_q, rq2_q;
    logic [ADDR:0] rbin_s;
    logic [ADDR:0] count_q, count_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          accept;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b[ADDR] = g[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next-state logic for the pointers, the flags and the RF write-port handshake.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
        accept  = 1'b0;
        wbin_d  = wbin_q;
        ovf_d   = ovf_q;

        // The RF is reset by the same rsta, so no write is offered while it is held.
        accept  = wr_req & ~full_q & ~rsta;
        wbin_d  = wbin_q + (ADDR+1)'(accept);
        wgray_d = wbin_d ^ (wbin_d >> 1);

        rbin_s  = gray2bin(rq2_q);
        count_d = wbin_d - rbin_s;

        // The FIFO is full when the write pointer is one lap ahead of the read pointer.
        // In Gray code that means the top two bits are inverted and the rest are equal.
        full_d  = (wgray_d == {~rq2_q[ADDR:ADDR-1], rq2_q[ADDR-2:0]});
        afull_d = (count_d >= AFULL_LVL);

        // A rejected push must not be lost silently. Set takes priority over clear.
        if (wr_req && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers: pointers, synchroniser and registered flags.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            // NOTE: the synchroniser flops are reset too, so the first full compare after reset sees a defined read pointer.
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so rq2 takes the old rq1 and both flop stages stay real.
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= rptr_gray_b;
            rq2_q   <= rq1_q;
            count_q <= count_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ram_en    = accept;
    assign ram_wr    = accept;
    assign ram_addr  = wbin_q[ADDR-1:0];
    assign ram_din   = wr_data;
    assign wptr_gray = wgray_q;
    assign full      = full_q;
    assign afull     = afull_q;
    assign wr_count  = count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed and randomised bench for the async FIFO write controller.
`timescale 1ns/1ps
module tb_afifo_wr_ctrl;

    localparam int WIDTH = 8;
    localparam int ADDR  = 6;
    localparam int DEPTH = 1 << ADDR;

    logic              clka = 1'b0;
    logic              clkb = 1'b0;
    logic              rsta;
    logic              wr_req;
    logic [WIDTH-1:0]  wr_data;
    logic              ovf_clr;
    logic [ADDR:0]     rptr_gray_b;
    logic              ram_en, ram_wr;
    logic [ADDR-1:0]   ram_addr;
    logic [WIDTH-1:0]  ram_din;
    logic [ADDR:0]     wptr_gray;
    logic              full, afull, ovf;
    logic [ADDR:0]     wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the register file plus the ordered list of words written and not yet read.
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  q [$];

    afifo_wr_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .AFULL_TH(4)) dut (
        .clka(clka), .rsta(rsta), .wr_req(wr_req), .wr_data(wr_data),
        .ovf_clr(ovf_clr), .rptr_gray_b(rptr_gray_b),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
        .wptr_gray(wptr_gray), .full(full), .afull(afull),
        .wr_count(wr_count), .ovf(ovf)
    );

    always #5   clka = ~clka;
    always #8.5 clkb = ~clkb;

    always @(posedge clka) begin
        if (ram_wr) begin
            mem[ram_addr] = ram_din;
            q.push_back(ram_din);
        end
    end

    function automatic logic [ADDR:0] g2b(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b[ADDR] = g[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic do_reset();
        wr_req = 1'b0; wr_data = '0; ovf_clr = 1'b0; rptr_gray_b = '0;
        rsta = 1'b1;
        tick();
        tick();
        rsta = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        // Push three words and then assert reset mid-cycle while a push is pending.
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(i);
            tick();
        end
        #3;
        rsta = 1'b1;
        #1;
        n_checks++; if (wptr_gray !== '0) begin n_fail++; $display("FAIL rst_wptr: got %b exp 0", wptr_gray); end
        n_checks++; if (wr_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", wr_count); end
        n_checks++; if ({full, afull, ovf} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {full, afull, ovf}); end
        n_checks++; if ({ram_en, ram_wr} !== 2'b00) begin n_fail++; $display("FAIL rst_ram_en: got %b exp 00", {ram_en, ram_wr}); end
        n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0d exp 0", ram_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_hold_en: got %b exp 0", ram_en); end
            n_checks++; if (wptr_gray !== '0) begin n_fail++; $display("FAIL rst_hold_wptr: got %b exp 0", wptr_gray); end
        end
        #3;
        rsta = 1'b0;
        #1;
        n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL rst_first_en: got %b exp 1", ram_en); end
        n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL rst_first_addr: got %0d exp 0", ram_addr); end
        tick();
        wr_req = 1'b0;
        n_checks++; if (wptr_gray !== 7'd1) begin n_fail++; $display("FAIL rst_first_wptr: got %b exp 0000001", wptr_gray); end
        n_checks++; if (wr_count !== 7'd1) begin n_fail++; $display("FAIL rst_first_count: got %0d exp 1", wr_count); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr_req  = 1'b1;
            wr_data = 8'(i);
            #1;
            n_checks++; if (ram_en !== 1'b1 || ram_wr !== 1'b1) begin n_fail++; $display("FAIL fill_en[%0d]: got %b%b exp 11", i, ram_en, ram_wr); end
            n_checks++; if (ram_addr !== 6'(i)) begin n_fail++; $display("FAIL fill_addr[%0d]: got %0d exp %0d", i, ram_addr, i); end
            n_checks++; if (ram_din !== 8'(i)) begin n_fail++; $display("FAIL fill_din[%0d]: got %h exp %h", i, ram_din, 8'(i)); end
            n_checks++; if (wr_count !== 7'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, wr_count, i); end
            n_checks++; if (afull !== (i >= 60)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b exp %b", i, afull, i >= 60); end
            n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_early_full[%0d]: got %b exp 0", i, full); end
            tick();
        end
        wr_req = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b exp 1", full); end
        n_checks++; if (afull !== 1'b1) begin n_fail++; $display("FAIL fill_afull_end: got %b exp 1", afull); end
        n_checks++; if (wptr_gray !== 7'b1100000) begin n_fail++; $display("FAIL fill_wptr: got %b exp 1100000", wptr_gray); end
        n_checks++; if (wr_count !== 7'd64) begin n_fail++; $display("FAIL fill_count_end: got %0d exp 64", wr_count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2; i++) begin
            wr_req = 1'b1;
            #1;
            n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL ovf_ram_en[%0d]: got %b exp 0", i, ram_en); end
            tick();
            n_checks++; if (wptr_gray !== 7'b1100000) begin n_fail++; $display("FAIL ovf_wptr[%0d]: got %b exp 1100000", i, wptr_gray); end
            n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set[%0d]: got %b exp 1", i, ovf); end
        end
        ovf_clr = 1'b1;
        tick();
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b exp 1", ovf); end
        wr_req = 1'b0;
        tick();
        ovf_clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b exp 0", ovf); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_kept: got %b exp 1", full); end
    endtask

    task automatic test_release();
        rptr_gray_b = 7'b0000001;
        tick();
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL rel_edge1: got %b exp 1", full); end
        tick();
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL rel_edge2: got %b exp 1", full); end
        tick();
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rel_edge3: got %b exp 0", full); end
        n_checks++; if (wr_count !== 7'd63) begin n_fail++; $display("FAIL rel_count: got %0d exp 63", wr_count); end
        n_checks++; if (afull !== 1'b1) begin n_fail++; $display("FAIL rel_afull: got %b exp 1", afull); end
        wr_req  = 1'b1;
        wr_data = 8'hA5;
        #1;
        n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL rel_en: got %b exp 1", ram_en); end
        n_checks++; if (ram_addr !== 6'd0) begin n_fail++; $display("FAIL rel_wrap_addr: got %0d exp 0", ram_addr); end
        tick();
        wr_req = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL rel_refull: got %b exp 1", full); end
        n_checks++; if (wptr_gray !== 7'b1100001) begin n_fail++; $display("FAIL rel_wptr: got %b exp 1100001", wptr_gray); end
    endtask

    task automatic test_long_wrap();
        logic [ADDR:0] wb, prev, h1, h2, occ, exp_g;
        do_reset();
        wb = '0; prev = '0; h1 = '0; h2 = '0;
        for (int i = 0; i < 300; i++) begin
            wr_req  = 1'b1;
            wr_data = 8'(i);
            #1;
            occ = wb - g2b(rptr_gray_b);
            n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL wrap_en[%0d]: got %b exp 1", i, ram_en); end
            n_checks++; if (ram_addr !== wb[ADDR-1:0]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d exp %0d", i, ram_addr, wb[ADDR-1:0]); end
            n_checks++; if (occ >= 7'(DEPTH)) begin n_fail++; $display("FAIL wrap_unread_slot[%0d]: occupancy %0d limit %0d", i, occ, DEPTH - 1); end
            tick();
            wb = wb + 7'd1;
            exp_g = wb ^ (wb >> 1);
            n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full[%0d]: got %b exp 0", i, full); end
            n_checks++; if ($countones(wptr_gray ^ prev) != 1) begin n_fail++; $display("FAIL wrap_gray_step[%0d]: got %b from %b exp one bit change", i, wptr_gray, prev); end
            n_checks++; if (wptr_gray !== exp_g) begin n_fail++; $display("FAIL wrap_gray[%0d]: got %b exp %b", i, wptr_gray, exp_g); end
            prev = wptr_gray;
            h2 = h1;
            h1 = wptr_gray;
            rptr_gray_b = h2;
        end
        wr_req = 1'b0;
    endtask

    task automatic test_random();
        int wcnt;
        int rd_bin;
        bit done;
        logic [ADDR:0] rb7;
        logic [WIDTH-1:0] exp_w;
        do_reset();
        q.delete();
        wcnt = 0; rd_bin = 0; done = 1'b0;
        fork
            begin
                for (int c = 0; c < 2000; c++) begin
                    wr_req  = ($urandom_range(0, 9) < 7);
                    wr_data = 8'($urandom);
                    #1;
                    n_checks++; if (ram_en !== (wr_req & ~full)) begin n_fail++; $display("FAIL rnd_accept[%0d]: got %b exp %b", c, ram_en, wr_req & ~full); end
                    if (ram_en) begin
                        n_checks++; if (ram_addr !== wcnt[ADDR-1:0]) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %0d exp %0d", c, ram_addr, wcnt[ADDR-1:0]); end
                        n_checks++; if (q.size() >= DEPTH) begin n_fail++; $display("FAIL rnd_overwrite[%0d]: occupancy %0d limit %0d", c, q.size(), DEPTH - 1); end
                        wcnt++;
                    end
                    tick();
                    n_checks++; if (int'(wr_count) < q.size()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d exp >= %0d", c, wr_count, q.size()); end
                end
                wr_req = 1'b0;
                done = 1'b1;
            end
            begin
                for (int k = 0; k < 5000; k++) begin
                    @(posedge clkb);
                    if (done && q.size() == 0) break;
                    if ((done || $urandom_range(0, 1) == 1) && q.size() > 0) begin
                        exp_w = q.pop_front();
                        rb7 = 7'(rd_bin);
                        n_checks++; if (mem[rb7[ADDR-1:0]] !== exp_w) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h exp %h", rd_bin, mem[rb7[ADDR-1:0]], exp_w); end
                        rd_bin++;
                        rb7 = 7'(rd_bin);
                        rptr_gray_b = rb7 ^ (rb7 >> 1);
                    end
                end
            end
        join
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d words left exp 0", q.size()); end
        n_checks++; if (rd_bin != wcnt) begin n_fail++; $display("FAIL rnd_total: got %0d read exp %0d", rd_bin, wcnt); end
        repeat (4) tick();
        n_checks++; if (wr_count !== '0) begin n_fail++; $display("FAIL rnd_empty_count: got %0d exp 0", wr_count); end
    endtask

    initial begin
        rsta = 1'b1; wr_req = 1'b0; wr_data = '0; ovf_clr = 1'b0; rptr_gray_b = '0;
        tick();
        tick();
        rsta = 1'b0;
        tick();
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_long_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
